// File: rtl/thread_switch_controller.sv
// Thread switch controller: picks when to leave the running hardware thread,
// saves its resume PC and redirects fetch to the next active thread.
module thread_switch_controller #(
  parameter int NUM_THREADS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [ADDR_WIDTH-1:0] PC_STRIDE = 'h1000,
  parameter int MISS_THRESHOLD = 4,
  parameter int QUANTUM        = 1024,
  parameter int DRAIN_CYCLES   = 3,
  localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dc_miss,
  input  logic [NUM_THREADS-1:0] thread_active,
  input  logic                  resume_valid,
  input  logic [ADDR_WIDTH-1:0] resume_pc,
  output logic                  thread_switch,
  output logic [TW-1:0]         thread_id,
  output logic                  tc_load_pc_we,
  output logic [ADDR_WIDTH-1:0] tc_load_pc_new_pc,
  output logic [31:0]           switch_count
);

  localparam int MW = $clog2(MISS_THRESHOLD + 1);
  localparam int QW = $clog2(QUANTUM + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [MW-1:0] MISS_MAX  = MW'(MISS_THRESHOLD);
  localparam logic [QW-1:0] Q_MAX     = QW'(QUANTUM);
  localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    RUN,
    SWITCH,
    DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         thread_id_q, thread_id_d;
  logic [TW-1:0]         nxt_q, nxt_d;
  logic [MW-1:0]         miss_cnt_q, miss_cnt_d;
  logic [QW-1:0]         quantum_cnt_q, quantum_cnt_d;
  logic [DW-1:0]         drain_cnt_q, drain_cnt_d;
  logic [31:0]           switch_count_q, switch_count_d;
  logic                  thread_switch_q, thread_switch_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] new_pc_q, new_pc_d;
  logic [ADDR_WIDTH-1:0] saved_pc_q [NUM_THREADS];
  logic [ADDR_WIDTH-1:0] saved_pc_d [NUM_THREADS];

  logic          nxt_found;
  logic [TW-1:0] nxt_idx;
  logic [MW-1:0] miss_inc;
  logic [QW-1:0] quantum_inc;
  logic          trigger;
  int            j;

  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = thread_id_q;
    j         = 0;
    for (int k = 1; k < NUM_THREADS; k++) begin
      j = (int'(thread_id_q) + k) % NUM_THREADS;
      if (!nxt_found && thread_active[j]) begin
        nxt_found = 1'b1;
        nxt_idx   = TW'(j);
      end
    end
  end

  // Increments include the current cycle so the Nth miss cycle is the trigger.
  always_comb begin
    miss_inc    = '0;
    quantum_inc = Q_MAX;
    if (dc_miss) begin
      miss_inc = (miss_cnt_q == MISS_MAX) ? MISS_MAX : miss_cnt_q + 1'b1;
    end
    if (quantum_cnt_q != Q_MAX) begin
      quantum_inc = quantum_cnt_q + 1'b1;
    end
    trigger = (miss_inc == MISS_MAX) | (quantum_inc == Q_MAX) |
              ~thread_active[thread_id_q];
  end

  always_comb begin
    state_d         = state_q;
    thread_id_d     = thread_id_q;
    nxt_d           = nxt_q;
    miss_cnt_d      = miss_cnt_q;
    quantum_cnt_d   = quantum_cnt_q;
    drain_cnt_d     = drain_cnt_q;
    switch_count_d  = switch_count_q;
    saved_pc_d      = saved_pc_q;
    thread_switch_d = 1'b0;
    we_d            = 1'b0;
    new_pc_d        = '0;
    unique case (state_q)
      RUN: begin
        miss_cnt_d    = miss_inc;
        quantum_cnt_d = quantum_inc;
        if (trigger && resume_valid && nxt_found) begin
          saved_pc_d[thread_id_q] = resume_pc;
          nxt_d           = nxt_idx;
          state_d         = SWITCH;
          thread_switch_d = 1'b1;
          we_d            = 1'b1;
          new_pc_d        = saved_pc_q[nxt_idx];
        end
      end
      SWITCH: begin
        thread_id_d    = nxt_q;
        switch_count_d = switch_count_q + 32'd1;
        miss_cnt_d     = '0;
        quantum_cnt_d  = '0;
        drain_cnt_d    = DRAIN_MAX;
        state_d        = DRAIN;
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q - 1'b1;
        if (drain_cnt_q == DW'(1)) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      thread_id_q     <= '0;
      nxt_q           <= '0;
      miss_cnt_q      <= '0;
      quantum_cnt_q   <= '0;
      drain_cnt_q     <= '0;
      switch_count_q  <= '0;
      thread_switch_q <= 1'b0;
      we_q            <= 1'b0;
      new_pc_q        <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        saved_pc_q[i] <= RESET_PC + ADDR_WIDTH'(i) * PC_STRIDE;
      end
    end else begin
      state_q         <= state_d;
      thread_id_q     <= thread_id_d;
      nxt_q           <= nxt_d;
      miss_cnt_q      <= miss_cnt_d;
      quantum_cnt_q   <= quantum_cnt_d;
      drain_cnt_q     <= drain_cnt_d;
      switch_count_q  <= switch_count_d;
      thread_switch_q <= thread_switch_d;
      we_q            <= we_d;
      new_pc_q        <= new_pc_d;
      saved_pc_q      <= saved_pc_d;
    end
  end

  assign thread_switch     = thread_switch_q;
  assign thread_id         = thread_id_q;
  assign tc_load_pc_we     = we_q;
  assign tc_load_pc_new_pc = new_pc_q;
  assign switch_count      = switch_count_q;

endmodule
